// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode constants, idle pattern and frame
// field positions, used by both the receive and transmit sides.
package uart_pkg;

  localparam int PAR_EVEN = 0;
  localparam int PAR_ODD  = 1;

  // Widest supported character is 9 bits; callers size-cast to their width.
  function automatic logic [8:0] idle_pattern();
    return '1;
  endfunction

  function automatic int stop_idx(input int data_bits, input int parity_en);
    return data_bits + parity_en;
  endfunction

  function automatic int parity_idx(input int data_bits);
    return data_bits;
  endfunction

  function automatic int data_msb(input int data_bits);
    return data_bits - 1;
  endfunction

endpackage

// File: rtl/uart_rx_holding_fifo_if.sv
// Handshake bundle between the receive controller/consumers and the
// receive holding FIFO.
interface uart_rx_holding_fifo_if #(
  parameter int DATA_BITS = 7,
  parameter int DEPTH     = 4,
  parameter int PARITY_EN = 1
);
  localparam int FW = DATA_BITS + PARITY_EN + 1;
  localparam int AW = $clog2(DEPTH);

  logic                 load;
  logic [FW-1:0]        data_in;
  logic                 rd_en;
  logic                 ovr_clr;
  logic [DATA_BITS-1:0] rd_data;
  logic                 rd_parity_err;
  logic                 rd_frame_err;
  logic                 empty;
  logic                 full;
  logic [AW:0]          count;
  logic                 overrun;

  modport master (
    output load, data_in, rd_en, ovr_clr,
    input  rd_data, rd_parity_err, rd_frame_err, empty, full, count, overrun
  );

  modport slave (
    input  load, data_in, rd_en, ovr_clr,
    output rd_data, rd_parity_err, rd_frame_err, empty, full, count, overrun
  );

endinterface

// File: rtl/uart_frame_check.sv
// Combinational parity and stop-bit check of one received character frame.
module uart_frame_check
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 7,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  localparam int FW = DATA_BITS + PARITY_EN + 1
) (
  input  logic [FW-1:0]        frame,
  output logic [DATA_BITS-1:0] data,
  output logic                 parity_err,
  output logic                 frame_err
);
  localparam int  STOP_IDX = stop_idx(DATA_BITS, PARITY_EN);
  localparam int  PAR_IDX  = parity_idx(DATA_BITS);
  localparam int  DATA_MSB = data_msb(DATA_BITS);
  localparam logic ODD_MODE = (PARITY_ODD == PAR_ODD);

  assign data      = frame[DATA_MSB:0];
  assign frame_err = ~frame[STOP_IDX];

  // XOR over data plus parity bit is 0 for a good even frame, 1 for good odd.
  generate
    if (PARITY_EN != 0) begin : g_parity
      assign parity_err = (^frame[PAR_IDX:0]) != ODD_MODE;
    end else begin : g_no_parity
      assign parity_err = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/uart_rx_holding_fifo.sv
// Receive holding FIFO: queues checked characters with their error flags
// and reports sticky overrun when a frame arrives while full.
module uart_rx_holding_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 7,
  parameter int DEPTH      = 4,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = PAR_EVEN
) (
  input logic clk,
  input logic reset,
  uart_rx_holding_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = DATA_BITS + 2;

  logic [EW-1:0]        mem [DEPTH];
  logic [AW:0]          wr_ptr;
  logic [AW:0]          rd_ptr;
  logic [DATA_BITS-1:0] chk_data;
  logic                 chk_parity_err;
  logic                 chk_frame_err;
  logic [EW-1:0]        entry;
  logic [EW-1:0]        head;
  logic                 is_empty;
  logic                 is_full;
  logic                 do_push;
  logic                 do_pop;

  uart_frame_check #(
    .DATA_BITS (DATA_BITS),
    .PARITY_EN (PARITY_EN),
    .PARITY_ODD(PARITY_ODD)
  ) u_check (
    .frame     (bus.data_in),
    .data      (chk_data),
    .parity_err(chk_parity_err),
    .frame_err (chk_frame_err)
  );

  assign entry    = {chk_frame_err, chk_parity_err, chk_data};
  assign is_empty = (wr_ptr == rd_ptr);
  assign is_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // When full, a same-cycle pop frees the head slot that the push then reuses.
  assign do_pop  = bus.rd_en & ~is_empty;
  assign do_push = bus.load & (~is_full | bus.rd_en);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= entry;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      bus.overrun <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (bus.load && is_full && !bus.rd_en) begin
        bus.overrun <= 1'b1;
      end else if (bus.ovr_clr) begin
        bus.overrun <= 1'b0;
      end
    end
  end

  assign head              = mem[rd_ptr[AW-1:0]];
  assign bus.empty         = is_empty;
  assign bus.full          = is_full;
  assign bus.count         = wr_ptr - rd_ptr;
  assign bus.rd_data       = is_empty ? DATA_BITS'(idle_pattern()) : head[DATA_BITS-1:0];
  assign bus.rd_parity_err = is_empty ? 1'b0 : head[DATA_BITS];
  assign bus.rd_frame_err  = is_empty ? 1'b0 : head[DATA_BITS+1];

endmodule

// File: tb/tb_uart_rx_holding_fifo.sv
// Bench for uart_rx_holding_fifo (7 data bits, even parity, depth 4):
// directed vector table, hand-written corner sequences, random vs queue model.
module tb_uart_rx_holding_fifo;

  typedef struct packed {
    logic [6:0] data;
    logic       perr;
    logic       ferr;
    logic [2:0] count;
    logic       empty;
    logic       full;
    logic       ovr;
  } out_t;

  typedef struct packed {
    logic       load;
    logic [8:0] frame;
    logic       rd_en;
    logic       ovr_clr;
    out_t       exp;
  } vec_t;

  typedef struct packed {
    logic [6:0] data;
    logic       perr;
    logic       ferr;
  } entry_t;

  logic clk;
  logic reset;
  int   tests;
  int   failed;

  entry_t model_q[$];
  logic   model_ovr;
  vec_t   vecs [16];

  uart_rx_holding_fifo_if #(.DATA_BITS(7), .DEPTH(4), .PARITY_EN(1)) bus ();

  uart_rx_holding_fifo #(
    .DATA_BITS (7),
    .DEPTH     (4),
    .PARITY_EN (1),
    .PARITY_ODD(0)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] mkFrame(input logic [6:0] d, input logic p, input logic stop);
    return {stop, p, d};
  endfunction

  // Frame with correct even parity and a good stop bit.
  function automatic logic [8:0] goodFrame(input logic [6:0] d);
    return {1'b1, logic'($countones(d) % 2), d};
  endfunction

  function automatic out_t mkOut(input logic [6:0] d, input logic pe, input logic fe,
                                 input int cnt, input logic ovr);
    out_t o;
    o.data  = d;
    o.perr  = pe;
    o.ferr  = fe;
    o.count = 3'(cnt);
    o.empty = (cnt == 0);
    o.full  = (cnt == 4);
    o.ovr   = ovr;
    return o;
  endfunction

  function automatic vec_t mkVec(input logic ld, input logic [8:0] fr, input logic rd,
                                 input logic clr, input out_t e);
    vec_t v;
    v.load    = ld;
    v.frame   = fr;
    v.rd_en   = rd;
    v.ovr_clr = clr;
    v.exp     = e;
    return v;
  endfunction

  function automatic out_t modelOut();
    if (model_q.size() == 0) return mkOut(7'h7F, 1'b0, 1'b0, 0, model_ovr);
    return mkOut(model_q[0].data, model_q[0].perr, model_q[0].ferr, model_q.size(), model_ovr);
  endfunction

  function automatic out_t actualOut();
    out_t o;
    o.data  = bus.rd_data;
    o.perr  = bus.rd_parity_err;
    o.ferr  = bus.rd_frame_err;
    o.count = bus.count;
    o.empty = bus.empty;
    o.full  = bus.full;
    o.ovr   = bus.overrun;
    return o;
  endfunction

  // Reference behaviour: queue of checked entries, decisions on pre-edge occupancy.
  task automatic modelStep(input logic ld, input logic [8:0] fr, input logic rd, input logic clr);
    entry_t e;
    int     n;
    n = model_q.size();
    e.data = fr[6:0];
    e.perr = (($countones(fr[7:0]) % 2) != 0);
    e.ferr = ~fr[8];
    if (rd && n > 0) void'(model_q.pop_front());
    if (ld && (n < 4 || rd)) model_q.push_back(e);
    if (ld && n == 4 && !rd) model_ovr = 1'b1;
    else if (clr)            model_ovr = 1'b0;
  endtask

  task automatic applyStimulus(input logic ld, input logic [8:0] fr, input logic rd, input logic clr);
    bus.load    = ld;
    bus.data_in = fr;
    bus.rd_en   = rd;
    bus.ovr_clr = clr;
    modelStep(ld, fr, rd, clr);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input out_t exp);
    out_t act;
    act = actualOut();
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got data=%h perr=%b ferr=%b count=%0d empty=%b full=%b ovr=%b, expected data=%h perr=%b ferr=%b count=%0d empty=%b full=%b ovr=%b",
               name, act.data, act.perr, act.ferr, act.count, act.empty, act.full, act.ovr,
               exp.data, exp.perr, exp.ferr, exp.count, exp.empty, exp.full, exp.ovr);
    end
  endtask

  task automatic clearInputs();
    bus.load    = 1'b0;
    bus.data_in = '0;
    bus.rd_en   = 1'b0;
    bus.ovr_clr = 1'b0;
  endtask

  task automatic doReset();
    clearInputs();
    reset = 1'b0;
    model_q.delete();
    model_ovr = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    tests  = 0;
    failed = 0;

    vecs[0]  = mkVec(0, 9'h0, 0, 0, mkOut(7'h7F, 0, 0, 0, 0));
    vecs[1]  = mkVec(1, mkFrame(7'h41, 0, 1), 0, 0, mkOut(7'h41, 0, 0, 1, 0));
    vecs[2]  = mkVec(0, 9'h0, 1, 0, mkOut(7'h7F, 0, 0, 0, 0));
    vecs[3]  = mkVec(1, mkFrame(7'h41, 1, 0), 0, 0, mkOut(7'h41, 1, 1, 1, 0));
    vecs[4]  = mkVec(0, 9'h0, 1, 0, mkOut(7'h7F, 0, 0, 0, 0));
    vecs[5]  = mkVec(1, goodFrame(7'h01), 0, 0, mkOut(7'h01, 0, 0, 1, 0));
    vecs[6]  = mkVec(1, goodFrame(7'h02), 0, 0, mkOut(7'h01, 0, 0, 2, 0));
    vecs[7]  = mkVec(1, goodFrame(7'h03), 0, 0, mkOut(7'h01, 0, 0, 3, 0));
    vecs[8]  = mkVec(1, goodFrame(7'h04), 0, 0, mkOut(7'h01, 0, 0, 4, 0));
    vecs[9]  = mkVec(1, goodFrame(7'h05), 0, 0, mkOut(7'h01, 0, 0, 4, 1));
    vecs[10] = mkVec(0, 9'h0, 0, 1, mkOut(7'h01, 0, 0, 4, 0));
    vecs[11] = mkVec(1, goodFrame(7'h10), 1, 0, mkOut(7'h02, 0, 0, 4, 0));
    vecs[12] = mkVec(0, 9'h0, 1, 0, mkOut(7'h03, 0, 0, 3, 0));
    vecs[13] = mkVec(0, 9'h0, 1, 0, mkOut(7'h04, 0, 0, 2, 0));
    vecs[14] = mkVec(0, 9'h0, 1, 0, mkOut(7'h10, 0, 0, 1, 0));
    vecs[15] = mkVec(0, 9'h0, 1, 0, mkOut(7'h7F, 0, 0, 0, 0));

    doReset();
    checkOutput("reset_state", mkOut(7'h7F, 0, 0, 0, 0));

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].load, vecs[i].frame, vecs[i].rd_en, vecs[i].ovr_clr);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Pointer wrap with alternating load/pop pairs.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, goodFrame(7'(8'h20 + i)), 0, 0);
      checkOutput($sformatf("wrap_load%0d", i), mkOut(7'(8'h20 + i), 0, 0, 1, 0));
      applyStimulus(0, 9'h0, 1, 0);
      checkOutput($sformatf("wrap_pop%0d", i), mkOut(7'h7F, 0, 0, 0, 0));
    end

    // Overrun set wins over a same-cycle clear; clear alone then takes effect.
    for (int i = 0; i < 4; i++) applyStimulus(1, goodFrame(7'(8'h30 + i)), 0, 0);
    applyStimulus(1, goodFrame(7'h3F), 0, 1);
    checkOutput("ovr_set_wins", mkOut(7'h30, 0, 0, 4, 1));
    applyStimulus(0, 9'h0, 0, 1);
    checkOutput("ovr_clear", mkOut(7'h30, 0, 0, 4, 0));

    // Async reset between edges with three entries held.
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus(1, goodFrame(7'(8'h50 + i)), 0, 0);
    checkOutput("pre_async_reset", mkOut(7'h50, 0, 0, 3, 0));
    clearInputs();
    #2 reset = 1'b0;
    model_q.delete();
    model_ovr = 1'b0;
    #1 checkOutput("async_reset", mkOut(7'h7F, 0, 0, 0, 0));
    @(posedge clk);
    #1 reset = 1'b1;

    // Random traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 9'($urandom), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 9) == 0));
      checkOutput($sformatf("rand%0d", i), modelOut());
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
